adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one 32-bit ripple-carry adder (FullAdder chain instance) between NUM_REQ independent requesters.
- Round-robin arbitration with per-requester valid/ready on the request side; a single valid/ready response channel tagged with the requester id.
- Operands are registered before the adder and the result is registered after it, so the adder's full carry chain gets a whole clock period.
- Sits between client blocks (accumulators, multiplier partial-sum stages) and the shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester id; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  input  32*NUM_REQ  operand B, same packing as req_a.
- req_cin  input  NUM_REQ  carry-in per requester.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_sum  output  32  a+b+cin, low 32 bits.
- rsp_cout  output  1  carry out of bit 31.

Behaviour:
- FSM states IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rr_ptr=0, operand registers=0. req_ready=0 outside IDLE.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0. If no req_valid is set, req_ready=0 and the FSM stays in IDLE.
  - On grant: latch req_a[g], req_b[g], req_cin[g] and g. Set rr_ptr <= (g+1) mod NUM_REQ. Go to EXEC.
- EXEC:
  - The adder sees only the latched operands.
  - At the clock edge, capture sum and cout into rsp_sum/rsp_cout, set rsp_id to the latched g, set rsp_valid=1, and go to RESP.
- RESP:
  - rsp_valid=1 and rsp_* are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge: rsp_valid <= 0 and go to IDLE. rsp_sum/rsp_id keep their last values.
  - No new request is accepted in RESP.
- Latency and throughput:
  - Handshake in cycle N gives rsp_valid high in cycle N+2.
  - Minimum spacing between accepted requests is 3 cycles with rsp_ready tied high.
- Arithmetic: unsigned 32-bit with carry. {rsp_cout, rsp_sum} = a + b + cin, a 33-bit exact result. Overflow is reported only through rsp_cout.
- Fairness:
  - A continuously valid requester is granted within NUM_REQ grants.
  - rr_ptr only advances on a grant.
- Request inputs are sampled only on the accept edge. Changing req_a/req_b after acceptance has no effect on the in-flight operation.
- A requester that drops req_valid before being granted loses nothing. It is not remembered.
- Reset asserted mid-operation (EXEC or RESP): the in-flight result is discarded, all outputs return to reset values immediately, and the FSM returns to IDLE with rr_ptr=0.
- rsp_ready high while rsp_valid=0 is ignored.

Test Plan:
- Single request: req_valid=4'b0001, a=0x0000_0005, b=0x0000_0003, cin=0, rsp_ready=1 -> req_ready=4'b0001 in cycle N; rsp_valid in N+2 with sum=0x0000_0008, cout=0, id=0.
- Carry wrap: requester 2 sends a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, id=2. Then a=0x8000_0000, b=0x8000_0000, cin=0 -> sum=0, cout=1.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, each grant 3 cycles apart; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/sum/id stay stable, req_ready stays 0 for every requester despite pending valids; once rsp_ready=1, rsp_valid drops the next cycle and the next grant occurs in IDLE.
- Pointer skip: after a grant to 1, only req_valid[0] is set -> grant to 0 (wrap); next grant with 0 and 3 valid -> 3 wins over 0 only if rr_ptr=1 and no valid at 1 or 2, otherwise the first valid from rr_ptr wins.
- Async reset in RESP: rst_n=0 between edges -> rsp_valid, rsp_sum, rsp_id drop to 0 without waiting for a clock edge; after release, the first grant with all requesters valid goes to requester 0.

Source files
------------

// File: rtl/adder_share_if.sv
// Bundle between the requesters/consumer and the shared-adder arbiter.
//
// Signals:
//   req_valid  [NUM_REQ]      per-requester request valid
//   req_ready  [NUM_REQ]      per-requester accept, at most one bit high
//   req_a      [32*NUM_REQ]   operand A, requester i in bits [32i+31:32i]
//   req_b      [32*NUM_REQ]   operand B, same packing
//   req_cin    [NUM_REQ]      carry-in per requester
//   rsp_valid                 result valid
//   rsp_ready                 consumer accepts the result
//   rsp_id     [ID_W]         requester that owns the result
//   rsp_sum    [32]           low 32 bits of a+b+cin
//   rsp_cout                  carry out of bit 31
//
// Modports: master = requesters plus result consumer, slave = arbiter.
interface adder_share_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Shares one 32-bit ripple-carry adder between NUM_REQ requesters.
//
// A round-robin arbiter picks one valid requester while idle, latches its
// operands, lets the ripple chain settle for a full cycle on the latched
// operands, registers {cout, sum} and holds the tagged result until the
// consumer takes it. One operation is in flight at a time.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    adder_share_if slave modport (request and response channels)
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   ID_W     requester id width, must equal clog2(NUM_REQ)
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input logic          clk,
  input logic          rst_n,
  adder_share_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr_q;

  // Operand registers feeding the adder.
  logic [31:0]     op_a_q;
  logic [31:0]     op_b_q;
  logic            op_cin_q;
  logic [ID_W-1:0] op_id_q;

  // Registered response.
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     rsp_sum_q;
  logic            rsp_cout_q;

  // Grant search results.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] rr_ptr_nxt;
  logic [31:0]     grant_a;
  logic [31:0]     grant_b;
  logic            grant_cin;

  // Adder outputs.
  logic [31:0]     add_sum;
  logic            add_cout;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  // The candidate index is one bit wider so rr_ptr+k cannot overflow before
  // the modulo fold, which keeps non-power-of-two NUM_REQ correct.
  always_comb begin
    logic [ID_W:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the requester just after the winner.
  always_comb begin
    logic [ID_W:0] inc;
    inc = {1'b0, grant_idx} + (ID_W+1)'(1);
    if (inc >= (ID_W+1)'(NUM_REQ)) begin
      rr_ptr_nxt = '0;
    end else begin
      rr_ptr_nxt = inc[ID_W-1:0];
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    grant_a   = '0;
    grant_b   = '0;
    grant_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_a   = bus.req_a[32*i +: 32];
        grant_b   = bus.req_b[32*i +: 32];
        grant_cin = bus.req_cin[i];
      end
    end
  end

  // Accept is combinational and only offered while idle.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == StIdle && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Full-adder chain on the latched operands; the carry ripples bit by bit.
  always_comb begin
    logic c;
    c       = op_cin_q;
    add_sum = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      add_sum[i] = op_a_q[i] ^ op_b_q[i] ^ c;
      c          = (op_a_q[i] & op_b_q[i]) | (c & (op_a_q[i] ^ op_b_q[i]));
    end
    add_cout = c;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            op_a_q   <= grant_a;
            op_b_q   <= grant_b;
            op_cin_q <= grant_cin;
            op_id_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_nxt;
            state_q  <= StExec;
          end
        end
        StExec: begin
          rsp_sum_q   <= add_sum;
          rsp_cout_q  <= add_cout;
          rsp_id_q    <= op_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          // Sum and id keep their last values after the handshake.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule
